// File: rtl/adder_arb.sv
// adder_arb: two requesters share one 32-bit adder under round-robin arbitration
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req0/req1         level add requests
//   a0,b0 / a1,b1     32-bit operands per requester
//   gnt0/gnt1         registered grant, high from latch until DONE
//   done0/done1       one-cycle result-valid pulse for the granted requester
//   sum, carry        registered 33-bit result, held until the next ADD
//   busy              high whenever the FSM is not IDLE
//   op_count          completed additions, modulo 256
module adder_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] sum,
    output logic        carry,
    output logic        busy,
    output logic [7:0]  op_count
);
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t      state;
    logic [31:0] opa, opb;
    logic        last1;
    logic        pick1;
    // requester 1 wins when alone, or when contested and requester 0 was served last
    assign pick1 = req1 & (~req0 | ~last1);
    assign busy  = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            op_count <= '0;
            last1    <= 1'b1;
            opa      <= '0;
            opb      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    if (req0 | req1) begin
                        gnt0  <= ~pick1;
                        gnt1  <= pick1;
                        opa   <= pick1 ? a1 : a0;
                        opb   <= pick1 ? b1 : b0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    {carry, sum} <= {1'b0, opa} + {1'b0, opb};
                    state        <= DONE;
                end
                DONE: begin
                    done0    <= gnt0;
                    done1    <= gnt1;
                    gnt0     <= 1'b0;
                    gnt1     <= 1'b0;
                    op_count <= op_count + 8'd1;
                    last1    <= gnt1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/adder_arb.md
ADDER_ARB -- requirements
Module: adder_arb

Interface
REQ-001 The module SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 The module SHALL have port: rst  input  1  synchronous, active-high reset sampled on the rising edge of clk.
REQ-003 The module SHALL have ports: req0 / req1  input  1  add request from requester 0 / 1 (level).
REQ-004 The module SHALL have ports: a0, b0 / a1, b1  input  32  operands of requester 0 / 1, stable while its req is high.
REQ-005 The module SHALL have ports: gnt0 / gnt1  output  1  requester 0 / 1 owns the shared adder (registered).
REQ-006 The module SHALL have ports: done0 / done1  output  1  one-cycle pulse, result for requester 0 / 1 is valid.
REQ-007 The module SHALL have port: sum  output  32  registered result, low 32 bits of a+b.
REQ-008 The module SHALL have port: carry  output  1  registered carry-out, bit 32 of the 33-bit a+b.
REQ-009 The module SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-010 The module SHALL have port: op_count  output  8  number of completed additions, modulo 256.

Function
REQ-011 The module SHALL contain exactly one 32-bit adder datapath, shared by both requesters.
REQ-012 The module SHALL implement FSM states IDLE, ADD and DONE.
REQ-013 In IDLE with no req high, the module SHALL stay in IDLE with all gnt and done outputs low.
REQ-014 In IDLE with any req high, the module SHALL select a winner, latch its a/b into internal operand registers, assert its gnt, and go to ADD on the next edge.
REQ-015 Arbitration SHALL be round-robin: with both req high, the requester not granted last wins; with one req high, that requester wins.
REQ-016 In ADD, the module SHALL register sum and carry from the latched operands, then go to DONE.
REQ-017 In DONE, the module SHALL pulse done of the granted requester for exactly one cycle, increment op_count, update the last-granted pointer, drop gnt, and return to IDLE.
REQ-018 Latency SHALL be: req first sampled high at edge N, gnt high after edge N, sum/carry valid after edge N+1, done high for the cycle after edge N+2; three cycles per operation, with no back-to-back overlap.
REQ-019 sum and carry SHALL hold their value from the last completed operation until the next ADD state.
REQ-020 Operand changes after the IDLE latch SHALL NOT affect the result of the operation in progress.
REQ-021 A requester deasserting req after grant SHALL NOT abort the operation; done SHALL still pulse.
REQ-022 A req still high in IDLE after its done SHALL be treated as a new request.
REQ-023 At most one of gnt0/gnt1 SHALL be high, and at most one of done0/done1 SHALL be high, in any cycle.
REQ-024 op_count SHALL wrap from 255 to 0.
REQ-025 Overflow beyond 33 bits SHALL NOT exist: carry SHALL be bit 32 of the zero-extended 33-bit sum.

Reset
REQ-026 When rst is high at a clock edge, the module SHALL go to IDLE regardless of current state, including mid-ADD or DONE; no done pulse SHALL occur for an aborted operation.
REQ-027 Reset values SHALL be: gnt0=gnt1=0, done0=done1=0, sum=0, carry=0, busy=0, op_count=0.
REQ-028 After reset, the last-granted pointer SHALL be requester 1, so requester 0 wins the first contested arbitration.

Verification
REQ-029 Single request: req0=1, a0=0000_0005, b0=0000_0007 -> gnt0 after edge N, sum=0000_000C with carry=0, done0 pulse after edge N+2, op_count=1.
REQ-030 Carry case: req1=1, a1=FFFF_FFFF, b1=0000_0007 -> sum=0000_0006, carry=1, done1 pulse only, with gnt0/done0 low throughout.
REQ-031 Contention: req0 and req1 held high from reset release -> grants alternate 0,1,0,1 and done pulses alternate, with one done per 3 cycles.
REQ-032 Operand change: a0 changed on the cycle after gnt0 rises -> result uses the originally latched a0.
REQ-033 Reset mid-op: rst asserted during ADD -> next cycle IDLE with all outputs at reset values, no done pulse, and the next contested grant goes to requester 0.
REQ-034 Wrap: 256 completed operations -> op_count returns to 0.
